// File: rtl/write_control_top.sv
// -----------------------------------------------------------------------------
// write_control_top
//
// Write-side pointer and full-flag controller for an 8-entry asynchronous FIFO.
// Accepts write requests in the wr_clk domain, advances a 4-bit binary pointer
// (3 address bits + wrap bit), publishes its Gray-coded form to the read
// domain, synchronizes the read domain's Gray pointer and derives a registered
// full flag plus a sticky overflow flag.
//
// Ports:
//   wr_clk      in   write-domain clock (rising edge)
//   reset_n     in   asynchronous active-low reset, clears all state
//   wr_en       in   write request
//   rd_ptr[3:0] in   Gray-coded read pointer, asynchronous to wr_clk
//   mem_we      out  memory write enable (wr_en & ~f_full), combinational
//   b_wr_ptr    out  binary write address (low 3 bits of the pointer)
//   MSB_wr_ptr  out  pointer wrap bit
//   wr_ptr[3:0] out  Gray-coded write pointer for the read domain
//   f_full      out  FIFO full
//   wr_ack      out  one-cycle pulse the cycle after an accepted write
//   overflow    out  sticky: write attempted while full
// -----------------------------------------------------------------------------
module write_control_top (
  input  logic       wr_clk,
  input  logic       reset_n,
  input  logic       wr_en,
  input  logic [3:0] rd_ptr,
  output logic       mem_we,
  output logic [2:0] b_wr_ptr,
  output logic       MSB_wr_ptr,
  output logic [3:0] wr_ptr,
  output logic       f_full,
  output logic       wr_ack,
  output logic       overflow
);

  function automatic logic [3:0] bin2gray(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [3:0] bin_q,   bin_d;
  logic [3:0] gray_q,  gray_d;
  logic [3:0] rd_s1_q, rd_s1_d;
  logic [3:0] rd_s2_q, rd_s2_d;
  logic       full_q,  full_d;
  logic       ack_q,   ack_d;
  logic       ovf_q,   ovf_d;
  logic       accept;

  assign accept = wr_en & ~full_q;

  always_comb begin
    bin_d   = bin_q;
    gray_d  = gray_q;
    rd_s1_d = rd_ptr;
    rd_s2_d = rd_s1_q;
    full_d  = full_q;
    ack_d   = accept;
    ovf_d   = ovf_q | (wr_en & full_q);

    if (accept) begin
      bin_d = bin_q + 4'd1;
    end
    // Gray pointer is loaded directly from the next binary value so it is a
    // clean flop output toward the read domain.
    gray_d = bin2gray(bin_d);

    // Full when the next write pointer equals the read pointer with the top
    // two Gray bits inverted (one full lap ahead). Uses the synchronized,
    // possibly stale read pointer, so release is late but never early.
    full_d = (gray_d == {~rd_s2_q[3:2], rd_s2_q[1:0]});
  end

  always_ff @(posedge wr_clk or negedge reset_n) begin
    if (!reset_n) begin
      bin_q   <= 4'd0;
      gray_q  <= 4'd0;
      rd_s1_q <= 4'd0;
      rd_s2_q <= 4'd0;
      full_q  <= 1'b0;
      ack_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      bin_q   <= bin_d;
      gray_q  <= gray_d;
      rd_s1_q <= rd_s1_d;
      rd_s2_q <= rd_s2_d;
      full_q  <= full_d;
      ack_q   <= ack_d;
      ovf_q   <= ovf_d;
    end
  end

  assign mem_we     = accept;
  assign b_wr_ptr   = bin_q[2:0];
  assign MSB_wr_ptr = bin_q[3];
  assign wr_ptr     = gray_q;
  assign f_full     = full_q;
  assign wr_ack     = ack_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_write_control_top.sv
module tb_write_control_top;

  logic       wr_clk;
  logic       reset_n;
  logic       wr_en;
  logic [3:0] rd_ptr;
  logic       mem_we;
  logic [2:0] b_wr_ptr;
  logic       MSB_wr_ptr;
  logic [3:0] wr_ptr;
  logic       f_full;
  logic       wr_ack;
  logic       overflow;

  write_control_top dut (
    .wr_clk     (wr_clk),
    .reset_n    (reset_n),
    .wr_en      (wr_en),
    .rd_ptr     (rd_ptr),
    .mem_we     (mem_we),
    .b_wr_ptr   (b_wr_ptr),
    .MSB_wr_ptr (MSB_wr_ptr),
    .wr_ptr     (wr_ptr),
    .f_full     (f_full),
    .wr_ack     (wr_ack),
    .overflow   (overflow)
  );

  initial wr_clk = 1'b0;
  always #5 wr_clk = ~wr_clk;

  typedef struct {
    logic       we;
    logic [3:0] bin;
    logic [3:0] g;
    logic       f;
    logic       a;
    logic       o;
  } exp_t;

  exp_t q[$];
  int   pending = 0;
  int   checks  = 0;
  int   errors  = 0;

  // Hand-written Gray table for binary 0..15.
  logic [3:0] gray_tbl [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                                4'b0110, 4'b0111, 4'b0101, 4'b0100,
                                4'b1100, 4'b1101, 4'b1111, 4'b1110,
                                4'b1010, 4'b1011, 4'b1001, 4'b1000};

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".b_wr_ptr"},   {1'b0, b_wr_ptr}, 4'd0);
    chk({tag, ".MSB_wr_ptr"}, {3'b0, MSB_wr_ptr}, 4'd0);
    chk({tag, ".wr_ptr"},     wr_ptr, 4'd0);
    chk({tag, ".f_full"},     {3'b0, f_full}, 4'd0);
    chk({tag, ".wr_ack"},     {3'b0, wr_ack}, 4'd0);
    chk({tag, ".overflow"},   {3'b0, overflow}, 4'd0);
  endtask

  // Drive one cycle of stimulus and queue the hand-computed expected result:
  // we = mem_we before the edge, the rest = outputs after the edge.
  task automatic step(input logic en, input logic [3:0] rd, input logic we,
                      input logic [3:0] bin, input logic [3:0] g,
                      input logic f, input logic a, input logic o);
    exp_t e;
    @(negedge wr_clk);
    wr_en  = en;
    rd_ptr = rd;
    e.we = we; e.bin = bin; e.g = g; e.f = f; e.a = a; e.o = o;
    q.push_back(e);
    pending++;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (pending != 0 && n < 50) begin
      @(negedge wr_clk);
      n++;
    end
    if (pending != 0) begin
      errors++;
      $display("FAIL drain: pending=%0d, expected 0", pending);
    end
  endtask

  // Monitor: pops one expectation per cycle, samples mem_we before the edge
  // and the registered outputs 1 time unit after it.
  initial begin
    exp_t e;
    forever begin
      @(negedge wr_clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("mem_we", {3'b0, mem_we}, {3'b0, e.we});
        @(posedge wr_clk);
        #1;
        chk("bin",      {MSB_wr_ptr, b_wr_ptr}, e.bin);
        chk("wr_ptr",   wr_ptr, e.g);
        chk("f_full",   {3'b0, f_full}, {3'b0, e.f});
        chk("wr_ack",   {3'b0, wr_ack}, {3'b0, e.a});
        chk("overflow", {3'b0, overflow}, {3'b0, e.o});
        pending--;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    wr_en   = 1'b0;
    rd_ptr  = 4'd0;

    // Reset hold with wr_en toggling: outputs stay zero, mem_we follows wr_en.
    for (int i = 0; i < 4; i++) begin
      @(negedge wr_clk);
      wr_en = i[0];
      #1;
      chk("rst.mem_we", {3'b0, mem_we}, {3'b0, wr_en});
      chk_zero("rst");
    end
    @(negedge wr_clk);
    wr_en   = 1'b0;
    reset_n = 1'b1;

    // Fill from empty: 8 accepts, then 2 rejected attempts.
    for (int k = 1; k <= 8; k++)
      step(1'b1, 4'd0, 1'b1, k[3:0], gray_tbl[k], (k == 8), 1'b1, 1'b0);
    step(1'b1, 4'd0, 1'b0, 4'd8, 4'b1100, 1'b1, 1'b0, 1'b1);
    step(1'b1, 4'd0, 1'b0, 4'd8, 4'b1100, 1'b1, 1'b0, 1'b1);

    // Release from full: f_full falls on the 3rd edge after rd_ptr changes.
    step(1'b0, 4'b0001, 1'b0, 4'd8, 4'b1100, 1'b1, 1'b0, 1'b1);
    step(1'b0, 4'b0001, 1'b0, 4'd8, 4'b1100, 1'b1, 1'b0, 1'b1);
    step(1'b0, 4'b0001, 1'b0, 4'd8, 4'b1100, 1'b0, 1'b0, 1'b1);
    step(1'b1, 4'b0001, 1'b1, 4'd9, 4'b1101, 1'b1, 1'b1, 1'b1);
    step(1'b0, 4'b0001, 1'b0, 4'd9, 4'b1101, 1'b1, 1'b0, 1'b1);
    drain();

    // Asynchronous reset between edges clears without waiting for a clock.
    @(posedge wr_clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk_zero("async_rst");
    @(negedge wr_clk);
    rd_ptr  = 4'd0;
    @(negedge wr_clk);
    reset_n = 1'b1;

    // Wrap-around with the reader keeping pace: 16 accepts, never full.
    for (int n = 1; n <= 16; n++)
      step(1'b1, gray_tbl[n-1], 1'b1, n[3:0], gray_tbl[n[3:0]], 1'b0, 1'b1, 1'b0);

    // Idle hold.
    for (int i = 0; i < 5; i++)
      step(1'b0, 4'd0, 1'b0, 4'd0, 4'b0000, 1'b0, 1'b0, 1'b0);

    // Reset mid-fill: 3 writes, reader position forces full, rejected write.
    step(1'b1, 4'd0, 1'b1, 4'd1, 4'b0001, 1'b0, 1'b1, 1'b0);
    step(1'b1, 4'd0, 1'b1, 4'd2, 4'b0011, 1'b0, 1'b1, 1'b0);
    step(1'b1, 4'd0, 1'b1, 4'd3, 4'b0010, 1'b0, 1'b1, 1'b0);
    step(1'b0, 4'b1110, 1'b0, 4'd3, 4'b0010, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'b1110, 1'b0, 4'd3, 4'b0010, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'b1110, 1'b0, 4'd3, 4'b0010, 1'b1, 1'b0, 1'b0);
    step(1'b1, 4'b1110, 1'b0, 4'd3, 4'b0010, 1'b1, 1'b0, 1'b1);
    drain();

    @(posedge wr_clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk_zero("midfill_rst");
    @(negedge wr_clk);
    wr_en  = 1'b0;
    rd_ptr = 4'd0;
    @(negedge wr_clk);
    reset_n = 1'b1;
    @(negedge wr_clk);
    wr_en = 1'b1;
    #1;
    chk("post_rst.addr", {1'b0, b_wr_ptr}, 4'd0);
    wr_en = 1'b0;
    step(1'b1, 4'd0, 1'b1, 4'd1, 4'b0001, 1'b0, 1'b1, 1'b0);
    step(1'b0, 4'd0, 1'b0, 4'd1, 4'b0001, 1'b0, 1'b0, 1'b0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/write_control_top.md
# write_control_top

Write-side pointer and full-flag controller for the 8-entry asynchronous FIFO, paired with the read control block. It accepts write requests in the `wr_clk` domain and drives the memory write enable and 3-bit write address. It publishes a Gray-coded 4-bit write pointer for the read domain. It synchronizes the read domain's Gray pointer and derives `f_full` and a sticky `overflow` flag.

## Interface
- No parameters: depth fixed at 8 entries, pointer width fixed at 4 bits (3 address bits + 1 wrap bit).
- One clock; reset is asynchronous and active-low (`wr_clk`, `reset_n`).
- `wr_clk` in 1: write-domain clock, all state updates on rising edge.
- `reset_n` in 1: asynchronous active-low reset; all registers and outputs clear immediately on assertion.
- `wr_en` in 1: write request, sampled on `wr_clk` rising edge.
- `rd_ptr` in 4: Gray-coded read pointer from the read domain; asynchronous to `wr_clk`.
- `mem_we` out 1: combinational memory write enable, `wr_en & ~f_full`.
- `b_wr_ptr` out 3: binary write address (low 3 bits of the binary pointer); registered.
- `MSB_wr_ptr` out 1: wrap bit (bit 3 of the binary pointer); registered.
- `wr_ptr` out 4: Gray-coded write pointer, `bin ^ (bin >> 1)`; registered, never decoded combinationally from outputs.
- `f_full` out 1: FIFO full; registered.
- `wr_ack` out 1: one-cycle pulse, the cycle after an accepted write.
- `overflow` out 1: sticky; set by a write attempt while full.

## Operation
- Internal 4-bit binary pointer `bin = {MSB_wr_ptr, b_wr_ptr}`.
- **Accept rule:** a write is accepted when `wr_en=1` and `f_full=0` at the edge.
  - On accept: `bin` increments by 1, modulo 16. `wr_ptr` loads Gray(`bin+1`) on the same edge.
  - On rejection or `wr_en=0`: `bin` and `wr_ptr` hold.
- **Read-pointer synchronizer:** 2-flop chain `rd_s1 -> rd_s2` on `wr_clk`, reset to 0. Only `rd_s2` is used in logic.
- **Full computation:**
  - `nxt_gray` = Gray of (`bin+1` if accepted, else `bin`).
  - `f_full` register loads `nxt_gray == {~rd_s2[3:2], rd_s2[1:0]}`.
- **wr_ack:** registered copy of the accept condition.
- **overflow:** set on an edge where `wr_en=1` and `f_full=1`. Cleared only by reset.
- **Wrap-around:** `bin` 15 -> 0, so `MSB_wr_ptr` toggles every 8 accepted writes.
  - Gray sequence: 0000, 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100, 1101, …, 1000, 0000.
- **Simultaneous events:**
  - Write accepted on the same edge the synchronized read pointer advances: both take effect, and `f_full` reflects the combined new values.
  - Write rejected while full: no pointer change, `mem_we=0`.
- **Reset mid-operation:** asynchronous clear of all state. In-flight write is discarded. Operation resumes on the first edge after deassertion.

## Timing
- **Reset values:** `b_wr_ptr=0`, `MSB_wr_ptr=0`, `wr_ptr=4'b0000`, `f_full=0`, `wr_ack=0`, `overflow=0`. `mem_we` follows `wr_en` while in reset, since `f_full=0`.
- **Pointer latency:** the pointer updates on the accepting edge. The memory write uses the pre-edge `b_wr_ptr` while `mem_we=1`.
- **Full assertion:** `f_full` rises on the same edge that accepts the write making the FIFO full. The next request is rejected with no bubble.
- **Full release:** a change on `rd_ptr` is reflected in `f_full` on the 3rd `wr_clk` rising edge after it becomes stable (2 sync + 1 register). This is pessimistic and never early.
- **wr_ack:** 1 cycle after the accepting edge, high for exactly 1 cycle per accepted write.
- **overflow:** rises 1 cycle after the rejected attempt's edge.

## Test plan
- **Reset:** hold `reset_n=0` with `wr_en=1` toggling.
  - Required: all registered outputs 0, `wr_ptr=0000`.
  - Asserting `reset_n` low between clock edges zeroes outputs without waiting for an edge.
- **Fill from empty:** `rd_ptr=0000`, `wr_en=1` for 10 edges.
  - Required: 8 accepts, `b_wr_ptr` 0..7 then 0, `MSB_wr_ptr=1`, `wr_ptr=1100`.
  - `f_full=1` after the 8th edge; edges 9–10 rejected with `mem_we=0`.
  - `overflow=1` one cycle after edge 9; `wr_ack` pulses 8 times.
- **Release from full:** from the full state, drive `rd_ptr=0001`.
  - Required: `f_full` falls on the 3rd edge.
  - Next write accepted: `wr_ptr=1101`, `f_full=1` again.
  - `overflow` stays 1.
- **Wrap-around:** `rd_ptr` tracks the written count (reader keeps pace), 16 accepted writes.
  - Required: `MSB_wr_ptr` toggles at writes 8 and 16, ending at `bin=0`, `wr_ptr=0000`.
  - `f_full` never asserts.
  - `wr_ptr` changes exactly 1 bit per accepted write.
- **Idle hold:** `wr_en=0` for 5 edges, not full.
  - Required: pointers constant, `wr_ack=0`, `mem_we=0`.
- **Reset mid-fill:** 3 accepted writes, then a write attempted while full (`overflow=1`), then `reset_n` pulsed low.
  - Required: immediate clear, `overflow=0`.
  - The first write after deassertion uses `b_wr_ptr=0`.
